// File: rtl/sram_access_seq_if.sv
// sram_access_seq_if
//   Pin bundle for the shared 16-bit cartridge SRAM.
//   master : the access sequencer. It drives address, byte enables, strobes and
//            write data, and receives read data.
//   slave  : the SRAM (or a model of it).
//   ram_addr      word address (byte address bits 23:1)
//   ram_bhe_n     upper byte enable, active low
//   ram_ble_n     lower byte enable, active low
//   ram_oe_n      output enable, active low
//   ram_we_n      write enable, active low
//   ram_data_in   data from the SRAM
//   ram_data_out  write data; the selected byte appears on both lanes
//   ram_data_oe   drive ram_data_out onto the SRAM bus
interface sram_access_seq_if;
    logic [22:0] ram_addr;
    logic        ram_bhe_n;
    logic        ram_ble_n;
    logic        ram_oe_n;
    logic        ram_we_n;
    logic [15:0] ram_data_in;
    logic [15:0] ram_data_out;
    logic        ram_data_oe;

    modport master (
        output ram_addr, ram_bhe_n, ram_ble_n, ram_oe_n, ram_we_n,
               ram_data_out, ram_data_oe,
        input  ram_data_in
    );

    modport slave (
        input  ram_addr, ram_bhe_n, ram_ble_n, ram_oe_n, ram_we_n,
               ram_data_out, ram_data_oe,
        output ram_data_in
    );
endinterface

// File: rtl/sram_access_seq.sv
// sram_access_seq
//   Runs the physical read and write cycles on the shared cartridge SRAM.
//   It serves two sources. SNES bus cycles arrive as already-decoded addresses.
//   The MCU sends request pulses. SNES work always wins, and the MCU only uses
//   slots where no SNES access is waiting. Exactly one access is on the SRAM at
//   any time, so OE and WE are never low together.
//
//   clk, rst_n        system clock, asynchronous active-low reset
//   snes_rd_n/wr_n    SNES strobes. They are asynchronous and get synchronised here.
//   rom_addr/rom_hit/is_writable  decoded address from the address decoder
//   snes_data_in      SNES write byte
//   snes_data_out     SNES read byte; snes_data_valid pulses when it updates
//   mcu_rrq/mcu_wrq   MCU request pulses; mcu_addr/mcu_data_in hold the operands
//   mcu_data_out      MCU read byte
//   mcu_rdy           high while no MCU request is pending or in progress
//   ram               SRAM pins (master side)
module sram_access_seq #(
    parameter int RD_CYCLES   = 4,   // OE low time in clocks (2..15)
    parameter int WR_CYCLES   = 4,   // WE low time in clocks (2..15)
    parameter int SYNC_STAGES = 2    // strobe synchroniser depth (2..3)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snes_rd_n,
    input  logic        snes_wr_n,
    input  logic [23:0] rom_addr,
    input  logic        rom_hit,
    input  logic        is_writable,
    input  logic [7:0]  snes_data_in,
    output logic [7:0]  snes_data_out,
    output logic        snes_data_valid,
    input  logic        mcu_rrq,
    input  logic        mcu_wrq,
    input  logic [23:0] mcu_addr,
    input  logic [7:0]  mcu_data_in,
    output logic [7:0]  mcu_data_out,
    output logic        mcu_rdy,
    sram_access_seq_if.master ram
);

    localparam logic [3:0] RD_LAST = 4'(RD_CYCLES - 1);
    // Write cycles use count 0 for setup and counts 1..WR_CYCLES with WE low.
    localparam logic [3:0] WR_LAST = 4'(WR_CYCLES);

    typedef enum logic [2:0] {IDLE, SRD, SWR, MRD, MWR, DONE} state_t;

    state_t state;
    logic [3:0] cnt;

    // Strobe synchronisers. Both strobes idle high, so the flops reset to 1.
    // A reset therefore never produces a false falling edge.
    logic [SYNC_STAGES-1:0] rd_sync, wr_sync;
    logic rd_hist, wr_hist;
    logic rd_fall, wr_fall, wr_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sync <= '1;
            wr_sync <= '1;
            rd_hist <= 1'b1;
            wr_hist <= 1'b1;
        end else begin
            rd_sync <= {rd_sync[SYNC_STAGES-2:0], snes_rd_n};
            wr_sync <= {wr_sync[SYNC_STAGES-2:0], snes_wr_n};
            rd_hist <= rd_sync[SYNC_STAGES-1];
            wr_hist <= wr_sync[SYNC_STAGES-1];
        end
    end

    assign rd_fall =  rd_hist & ~rd_sync[SYNC_STAGES-1];
    assign wr_fall =  wr_hist & ~wr_sync[SYNC_STAGES-1];
    assign wr_rise = ~wr_hist &  wr_sync[SYNC_STAGES-1];

    // Pending-request storage
    logic        snes_rd_pend, snes_wr_pend, mcu_pend, mcu_is_wr, wr_ok;
    logic [23:0] snes_rd_addr, snes_wr_addr, mcu_addr_q;
    logic [7:0]  snes_wr_data, mcu_data_q;
    logic        lane_hi;  // byte lane of the access in flight

    // Operands of whichever request IDLE will pick this cycle
    logic [23:0] nxt_addr;
    logic [7:0]  nxt_data;
    logic [7:0]  rd_byte;

    always_comb begin
        nxt_addr = mcu_addr_q;
        nxt_data = mcu_data_q;
        if (snes_wr_pend) begin
            nxt_addr = snes_wr_addr;
            nxt_data = snes_wr_data;
        end else if (snes_rd_pend) begin
            nxt_addr = snes_rd_addr;
        end
    end

    assign rd_byte = lane_hi ? ram.ram_data_in[15:8] : ram.ram_data_in[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            snes_rd_pend     <= 1'b0;
            snes_wr_pend     <= 1'b0;
            mcu_pend         <= 1'b0;
            mcu_is_wr        <= 1'b0;
            wr_ok            <= 1'b0;
            snes_rd_addr     <= '0;
            snes_wr_addr     <= '0;
            mcu_addr_q       <= '0;
            snes_wr_data     <= '0;
            mcu_data_q       <= '0;
            lane_hi          <= 1'b0;
            snes_data_out    <= '0;
            snes_data_valid  <= 1'b0;
            mcu_data_out     <= '0;
            mcu_rdy          <= 1'b1;
            ram.ram_addr     <= '0;
            ram.ram_bhe_n    <= 1'b1;
            ram.ram_ble_n    <= 1'b1;
            ram.ram_oe_n     <= 1'b1;
            ram.ram_we_n     <= 1'b1;
            ram.ram_data_out <= '0;
            ram.ram_data_oe  <= 1'b0;
        end else begin
            snes_data_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (snes_wr_pend || snes_rd_pend || mcu_pend) begin
                        ram.ram_addr     <= nxt_addr[23:1];
                        lane_hi          <= nxt_addr[0];
                        ram.ram_bhe_n    <= ~nxt_addr[0];
                        ram.ram_ble_n    <=  nxt_addr[0];
                        ram.ram_data_out <= {nxt_data, nxt_data};
                        cnt              <= '0;
                        if (snes_wr_pend) begin
                            snes_wr_pend    <= 1'b0;
                            ram.ram_data_oe <= 1'b1;
                            state           <= SWR;
                        end else if (snes_rd_pend) begin
                            snes_rd_pend <= 1'b0;
                            ram.ram_oe_n <= 1'b0;
                            state        <= SRD;
                        end else begin
                            mcu_pend <= 1'b0;
                            if (mcu_is_wr) begin
                                ram.ram_data_oe <= 1'b1;
                                state           <= MWR;
                            end else begin
                                ram.ram_oe_n <= 1'b0;
                                state        <= MRD;
                            end
                        end
                    end
                end

                SRD, MRD: begin
                    if (cnt == RD_LAST) begin
                        // Sample on the last OE-low cycle. The result shows in DONE.
                        ram.ram_oe_n  <= 1'b1;
                        ram.ram_bhe_n <= 1'b1;
                        ram.ram_ble_n <= 1'b1;
                        state         <= DONE;
                        if (state == SRD) begin
                            snes_data_out   <= rd_byte;
                            snes_data_valid <= 1'b1;
                        end else begin
                            mcu_data_out <= rd_byte;
                            mcu_rdy      <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end

                SWR, MWR: begin
                    if (cnt == WR_LAST) begin
                        ram.ram_we_n    <= 1'b1;
                        ram.ram_data_oe <= 1'b0;
                        ram.ram_bhe_n   <= 1'b1;
                        ram.ram_ble_n   <= 1'b1;
                        state           <= DONE;
                        if (state == MWR) mcu_rdy <= 1'b1;
                    end else begin
                        // Count 0 is the address/data setup cycle. WE falls after it.
                        ram.ram_we_n <= 1'b0;
                        cnt          <= cnt + 4'd1;
                    end
                end

                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // Event capture comes after the FSM. A new event in the same cycle
            // as its pend flag being consumed therefore re-arms the flag.
            if (rd_fall && rom_hit) begin
                snes_rd_addr <= rom_addr;   // last access wins
                snes_rd_pend <= 1'b1;
            end
            if (wr_fall) begin
                snes_wr_addr <= rom_addr;
                wr_ok        <= is_writable;
            end
            if (wr_rise && wr_ok) begin
                snes_wr_data <= snes_data_in;
                snes_wr_pend <= 1'b1;
            end
            // mcu_rdy low covers both pending and in progress. Gating on it
            // drops any request that arrives while the MCU slot is busy.
            if (mcu_rdy && (mcu_wrq || mcu_rrq)) begin
                mcu_addr_q <= mcu_addr;
                mcu_data_q <= mcu_data_in;
                mcu_is_wr  <= mcu_wrq;
                mcu_pend   <= 1'b1;
                mcu_rdy    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_access_seq.sv
// tb_sram_access_seq
//   Directed bench for sram_access_seq with its default parameters.
//   - A 16-word SRAM model is indexed by ram_addr[3:0].
//   - A negedge monitor counts strobe activity.
//   - A vector table covers single SNES reads and writes.
//   - Hand-written sequences cover reset, MCU/SNES contention and MCU request dropping.
module tb_sram_access_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        snes_rd_n, snes_wr_n;
    logic [23:0] rom_addr;
    logic        rom_hit, is_writable;
    logic [7:0]  snes_data_in, snes_data_out;
    logic        snes_data_valid;
    logic        mcu_rrq, mcu_wrq;
    logic [23:0] mcu_addr;
    logic [7:0]  mcu_data_in, mcu_data_out;
    logic        mcu_rdy;

    sram_access_seq_if rif();

    sram_access_seq dut (
        .clk(clk), .rst_n(rst_n),
        .snes_rd_n(snes_rd_n), .snes_wr_n(snes_wr_n),
        .rom_addr(rom_addr), .rom_hit(rom_hit), .is_writable(is_writable),
        .snes_data_in(snes_data_in), .snes_data_out(snes_data_out),
        .snes_data_valid(snes_data_valid),
        .mcu_rrq(mcu_rrq), .mcu_wrq(mcu_wrq), .mcu_addr(mcu_addr),
        .mcu_data_in(mcu_data_in), .mcu_data_out(mcu_data_out), .mcu_rdy(mcu_rdy),
        .ram(rif)
    );

    always #5 clk = ~clk;

    // SRAM model
    logic [15:0] mem [16];
    logic mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h0000;
            mem[0]    <= 16'h12C3;
            mem[2]    <= 16'hBEEF;
            mem_ready <= 1'b1;
        end else if (!rif.ram_we_n && rif.ram_data_oe) begin
            if (!rif.ram_ble_n) mem[rif.ram_addr[3:0]][7:0]  <= rif.ram_data_out[7:0];
            if (!rif.ram_bhe_n) mem[rif.ram_addr[3:0]][15:8] <= rif.ram_data_out[15:8];
        end
    end
    assign rif.ram_data_in = rif.ram_oe_n ? 16'h0000 : mem[rif.ram_addr[3:0]];

    // Strobe monitor
    int oe_cyc = 0, we_cyc = 0, we_pulses = 0, doe_cyc = 0, valid_cnt = 0, overlap = 0;
    logic prev_oe_n = 1'b1, prev_we_n = 1'b1, prev_doe = 1'b0, we_setup_ok = 1'b0;
    logic [22:0] oe_addr = '0, we_addr = '0;
    logic oe_bhe_n = 1'b1, oe_ble_n = 1'b1, we_bhe_n = 1'b1, we_ble_n = 1'b1;
    logic [15:0] we_data = '0;
    always @(negedge clk) begin
        prev_oe_n <= rif.ram_oe_n;
        prev_we_n <= rif.ram_we_n;
        prev_doe  <= rif.ram_data_oe;
        if (!rif.ram_oe_n) begin
            oe_cyc <= oe_cyc + 1;
            if (prev_oe_n) begin
                oe_addr  <= rif.ram_addr;
                oe_bhe_n <= rif.ram_bhe_n;
                oe_ble_n <= rif.ram_ble_n;
            end
        end
        if (!rif.ram_we_n) begin
            we_cyc <= we_cyc + 1;
            if (prev_we_n) begin
                we_pulses   <= we_pulses + 1;
                we_setup_ok <= prev_doe;
                we_addr     <= rif.ram_addr;
                we_data     <= rif.ram_data_out;
                we_bhe_n    <= rif.ram_bhe_n;
                we_ble_n    <= rif.ram_ble_n;
            end
        end
        if (rif.ram_data_oe) doe_cyc <= doe_cyc + 1;
        if (!rif.ram_oe_n && !rif.ram_we_n) overlap <= overlap + 1;
        if (snes_data_valid) valid_cnt <= valid_cnt + 1;
    end

    int n_checks = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one SNES read. lat is the number of clocks from driving RD low to
    // the negedge where valid is seen (-1 means never). It is 2 sync clocks plus
    // the 6 clocks from rd_fall to valid.
    task automatic do_read(input logic [23:0] a, input logic hit, output int lat);
        @(negedge clk);
        rom_addr = a; rom_hit = hit; snes_rd_n = 1'b0;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (snes_data_valid && lat < 0) lat = i;
        end
        snes_rd_n = 1'b1;
        cyc(4);
    endtask

    task automatic do_write(input logic [23:0] a, input logic wen, input logic [7:0] d);
        @(negedge clk);
        rom_addr = a; is_writable = wen; snes_wr_n = 1'b0;
        cyc(4);
        snes_data_in = d; snes_wr_n = 1'b1;
        cyc(20);
    endtask

    typedef struct {
        logic        is_wr;
        logic [23:0] addr;
        logic        en;        // rom_hit for reads, is_writable for writes
        logic [7:0]  wdata;
        logic [22:0] exp_addr;
        logic        exp_bhe_n;
        logic        exp_ble_n;
        logic [7:0]  exp_byte;  // read data or byte driven on both lanes
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    initial begin
        int lat, s_oe, s_we, s_wp, s_doe, s_val;
        int t_rdy, t_srd, t_val;
        logic [7:0] mcu_got, snes_got;
        logic seen;

        vecs[0] = '{1'b0, 24'h012345, 1'b1, 8'h00, 23'h0091A2, 1'b0, 1'b1, 8'hBE};
        vecs[1] = '{1'b0, 24'h012344, 1'b1, 8'h00, 23'h0091A2, 1'b1, 1'b0, 8'hEF};
        vecs[2] = '{1'b0, 24'h012345, 1'b0, 8'h00, 23'h0091A2, 1'b0, 1'b1, 8'hBE};
        vecs[3] = '{1'b1, 24'hE00010, 1'b1, 8'h5A, 23'h700008, 1'b1, 1'b0, 8'h5A};
        vecs[4] = '{1'b1, 24'hE00010, 1'b0, 8'h33, 23'h700008, 1'b1, 1'b0, 8'h33};
        vecs[5] = '{1'b1, 24'hE00011, 1'b1, 8'hC3, 23'h700008, 1'b0, 1'b1, 8'hC3};
        vecs[6] = '{1'b0, 24'hE00010, 1'b1, 8'h00, 23'h700008, 1'b1, 1'b0, 8'h5A};
        vecs[7] = '{1'b0, 24'hE00011, 1'b1, 8'h00, 23'h700008, 1'b0, 1'b1, 8'hC3};

        rst_n = 1'b0; snes_rd_n = 1'b1; snes_wr_n = 1'b1;
        rom_addr = '0; rom_hit = 1'b0; is_writable = 1'b0; snes_data_in = '0;
        mcu_rrq = 1'b0; mcu_wrq = 1'b0; mcu_addr = '0; mcu_data_in = '0;

        // Reset state
        cyc(3);
        check("rst_oe_n", rif.ram_oe_n, 1);
        check("rst_we_n", rif.ram_we_n, 1);
        check("rst_lanes_n", {rif.ram_bhe_n, rif.ram_ble_n}, 2'b11);
        check("rst_data_oe", rif.ram_data_oe, 0);
        check("rst_ram_addr", rif.ram_addr, 0);
        check("rst_snes_out", {snes_data_out, snes_data_valid}, 0);
        check("rst_mcu_out", mcu_data_out, 0);
        check("rst_mcu_rdy", mcu_rdy, 1);
        rst_n = 1'b1;
        cyc(3);

        // Reset during an SNES read: the access is abandoned and not retried
        rom_addr = 24'h012345; rom_hit = 1'b1; snes_rd_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (!rif.ram_oe_n) seen = 1'b1;
        end
        check("midsrd_oe_seen", seen, 1);
        #2 rst_n = 1'b0; snes_rd_n = 1'b1;
        #1;
        check("midsrd_oe_n", rif.ram_oe_n, 1);
        check("midsrd_lanes_n", {rif.ram_bhe_n, rif.ram_ble_n}, 2'b11);
        check("midsrd_mcu_rdy", mcu_rdy, 1);
        cyc(3);
        rst_n = 1'b1;
        s_oe = oe_cyc; s_val = valid_cnt;
        cyc(20);
        check("midsrd_no_valid", valid_cnt - s_val, 0);
        check("midsrd_no_oe", oe_cyc - s_oe, 0);

        // Vector table: single SNES accesses
        for (int i = 0; i < NV; i++) begin
            s_oe = oe_cyc; s_we = we_cyc; s_wp = we_pulses; s_doe = doe_cyc; s_val = valid_cnt;
            if (!vecs[i].is_wr) begin
                do_read(vecs[i].addr, vecs[i].en, lat);
                if (vecs[i].en) begin
                    check($sformatf("v%0d_rd_latency", i), lat, 8);
                    check($sformatf("v%0d_rd_valid_pulses", i), valid_cnt - s_val, 1);
                    check($sformatf("v%0d_rd_oe_cycles", i), oe_cyc - s_oe, 4);
                    check($sformatf("v%0d_rd_data", i), snes_data_out, vecs[i].exp_byte);
                    check($sformatf("v%0d_rd_addr", i), oe_addr, vecs[i].exp_addr);
                    check($sformatf("v%0d_rd_lanes", i), {oe_bhe_n, oe_ble_n},
                          {vecs[i].exp_bhe_n, vecs[i].exp_ble_n});
                end else begin
                    check($sformatf("v%0d_miss_no_oe", i), oe_cyc - s_oe, 0);
                    check($sformatf("v%0d_miss_no_valid", i), valid_cnt - s_val, 0);
                end
            end else begin
                do_write(vecs[i].addr, vecs[i].en, vecs[i].wdata);
                if (vecs[i].en) begin
                    check($sformatf("v%0d_wr_we_pulses", i), we_pulses - s_wp, 1);
                    check($sformatf("v%0d_wr_we_cycles", i), we_cyc - s_we, 4);
                    check($sformatf("v%0d_wr_doe_cycles", i), doe_cyc - s_doe, 5);
                    check($sformatf("v%0d_wr_setup", i), we_setup_ok, 1);
                    check($sformatf("v%0d_wr_data", i), we_data,
                          {vecs[i].exp_byte, vecs[i].exp_byte});
                    check($sformatf("v%0d_wr_addr", i), we_addr, vecs[i].exp_addr);
                    check($sformatf("v%0d_wr_lanes", i), {we_bhe_n, we_ble_n},
                          {vecs[i].exp_bhe_n, vecs[i].exp_ble_n});
                end else begin
                    check($sformatf("v%0d_ro_no_we", i), we_cyc - s_we, 0);
                    check($sformatf("v%0d_ro_no_doe", i), doe_cyc - s_doe, 0);
                end
            end
        end

        // The MCU read is queued first and owns the SRAM. The SNES read that
        // arrives one cycle later runs after DONE and the following IDLE cycle.
        s_oe = oe_cyc;
        @(negedge clk);
        rom_addr = 24'h012345; rom_hit = 1'b1; snes_rd_n = 1'b0;
        @(negedge clk);
        mcu_addr = 24'h000001; mcu_rrq = 1'b1;
        @(negedge clk);
        mcu_rrq = 1'b0;
        t_rdy = -1; t_srd = -1; t_val = -1; mcu_got = '0; snes_got = '0;
        for (int i = 0; i < 40; i++) begin
            if (mcu_rdy && t_rdy < 0) begin t_rdy = i; mcu_got = mcu_data_out; end
            if (t_rdy >= 0 && i > t_rdy && !rif.ram_oe_n && t_srd < 0) t_srd = i;
            if (snes_data_valid && t_val < 0) begin t_val = i; snes_got = snes_data_out; end
            @(negedge clk);
        end
        snes_rd_n = 1'b1;
        cyc(4);
        check("mix_mcu_done", t_rdy >= 0, 1);
        check("mix_mcu_data", mcu_got, 8'h12);
        check("mix_snes_data", snes_got, 8'hBE);
        check("mix_snes_after_mcu", t_val > t_rdy, 1);
        check("mix_srd_start_gap", t_srd - t_rdy, 2);
        check("mix_oe_cycles", oe_cyc - s_oe, 8);

        // MCU write, then a read request while busy. The read must be dropped.
        s_oe = oe_cyc; s_we = we_cyc; s_wp = we_pulses;
        @(negedge clk);
        mcu_addr = 24'h000005; mcu_data_in = 8'h77; mcu_wrq = 1'b1;
        @(negedge clk);
        mcu_wrq = 1'b0;
        check("mwr_rdy_drop", mcu_rdy, 0);
        mcu_addr = 24'h000002; mcu_rrq = 1'b1;
        @(negedge clk);
        mcu_rrq = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (mcu_rdy) seen = 1'b1;
        end
        check("mwr_rdy_return", seen, 1);
        cyc(15);
        check("mwr_we_pulses", we_pulses - s_wp, 1);
        check("mwr_we_cycles", we_cyc - s_we, 4);
        check("mwr_rrq_ignored", oe_cyc - s_oe, 0);
        check("mwr_rdy_idle", mcu_rdy, 1);

        // Read back the high byte that the MCU wrote, through the SNES path
        do_read(24'h012345, 1'b1, lat);
        check("mwr_readback", snes_data_out, 8'h77);
        check("mwr_readback_lat", lat, 8);

        check("no_oe_we_overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
